// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, state encoding and helpers for the register-file access controller
// Purpose: widths, register count, writeback queue depth and the controller state type.
// Ports: none (package).
package regfile_pkg;

  localparam int DATA_W   = 26;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 13;
  localparam int WB_DEPTH = 4;
  localparam int PTR_W    = $clog2(WB_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RD_CAP
  } ctrl_state_t;

  // Addresses at or above NUM_REGS have no backing register.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(NUM_REGS);
  endfunction

endpackage

// File: rtl/regfile_access_ctrl_wb_queue.sv
// rtl/regfile_access_ctrl_wb_queue.sv - writeback FIFO with parallel address match over queued entries
// Purpose: holds pending register writes in arrival order and reports whether either
//   read address targets any still-queued write.
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset (empties the queue)
//   i_push, i_push_addr/data    enqueue one write (ignored when full)
//   i_pop                       dequeue the head (ignored when empty)
//   o_full, o_empty             occupancy flags
//   o_head_addr, o_head_data    oldest queued write
//   i_match_a/b, o_match_a/b    address compare against every valid entry
module wb_queue
  import regfile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_data,
  input  logic [ADDR_W-1:0] i_match_a,
  input  logic [ADDR_W-1:0] i_match_b,
  output logic              o_match_a,
  output logic              o_match_b
);

  logic [ADDR_W-1:0]   r_addr [WB_DEPTH];
  logic [DATA_W-1:0]   r_data [WB_DEPTH];
  logic [WB_DEPTH-1:0] r_valid;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;

  logic w_push;
  logic w_pop;

  // One valid bit per slot: occupancy and the match mask come from the same bits.
  assign o_full  = &r_valid;
  assign o_empty = ~|r_valid;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      // Push and pop never share a slot: equal pointers mean empty (no pop) or full (no push).
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Payload needs no reset; r_valid qualifies every use.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= i_push_addr;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  always_comb begin
    o_match_a = 1'b0;
    o_match_b = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == i_match_a)) o_match_a = 1'b1;
      if (r_valid[i] && (r_addr[i] == i_match_b)) o_match_b = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - register-file port initiator with queued writebacks and read-after-write ordering
// Purpose: accepts operand reads and writebacks, queues writebacks, sequences the RF port so a read
//   is never served while an older write to the same register is still queued.
// Ports:
//   i_clk, i_rst_n                       clock, asynchronous active-low reset
//   i_rd_req_valid, o_rd_req_ready       operand read handshake; i_rd_addr_a/b source registers
//   o_op_valid, o_op_a, o_op_b           one-cycle operand pulse, values held until next pulse
//   i_wb_valid, o_wb_ready               writeback handshake; i_wb_addr/i_wb_data destination and value
//   o_wb_addr_err                        one-cycle pulse after an illegal writeback address is dropped
//   o_we_rf, o_a3, o_wd3                 RF write port (RF writes on negedge)
//   o_a1, o_a2, i_rd1, i_rd2             RF read port (RF registers data one posedge after sampling)
module regfile_access_ctrl
  import regfile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd_req_valid,
  output logic              o_rd_req_ready,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic              o_op_valid,
  output logic [DATA_W-1:0] o_op_a,
  output logic [DATA_W-1:0] o_op_b,
  input  logic              i_wb_valid,
  output logic              o_wb_ready,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_wb_addr_err,
  output logic              o_we_rf,
  output logic [ADDR_W-1:0] o_a1,
  output logic [ADDR_W-1:0] o_a2,
  output logic [ADDR_W-1:0] o_a3,
  output logic [DATA_W-1:0] o_wd3,
  input  logic [DATA_W-1:0] i_rd1,
  input  logic [DATA_W-1:0] i_rd2
);

  ctrl_state_t r_state;
  logic        r_legal_a;
  logic        r_legal_b;

  logic              w_full;
  logic              w_empty;
  logic              w_match_a;
  logic              w_match_b;
  logic              w_hazard;
  logic              w_rd_ready;
  logic              w_rd_fire;
  logic              w_wb_fire;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;

  // Match is against entries already queued, so a write pushed this cycle counts as younger.
  assign w_hazard   = w_match_a || w_match_b;
  assign w_rd_ready = (r_state == IDLE) && !(w_full || w_hazard);
  assign w_rd_fire  = i_rd_req_valid && w_rd_ready;
  assign w_wb_fire  = i_wb_valid && !w_full;
  assign w_push     = w_wb_fire && addr_legal(i_wb_addr);
  assign w_pop      = (r_state == WR);

  assign o_rd_req_ready = w_rd_ready;
  assign o_wb_ready     = !w_full;

  wb_queue u_wb_queue (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_push_addr (i_wb_addr),
    .i_push_data (i_wb_data),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .i_match_a   (i_rd_addr_a),
    .i_match_b   (i_rd_addr_b),
    .o_match_a   (w_match_a),
    .o_match_b   (w_match_b)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_legal_a     <= 1'b0;
      r_legal_b     <= 1'b0;
      o_we_rf       <= 1'b0;
      o_a1          <= '0;
      o_a2          <= '0;
      o_a3          <= '0;
      o_wd3         <= '0;
      o_op_valid    <= 1'b0;
      o_op_a        <= '0;
      o_op_b        <= '0;
      o_wb_addr_err <= 1'b0;
    end else begin
      o_op_valid    <= 1'b0;
      o_wb_addr_err <= w_wb_fire && !addr_legal(i_wb_addr);
      case (r_state)
        IDLE: begin
          // Drain when full, when the read would hit a queued write, or when nothing wants to read.
          if (!w_empty && (w_full || (i_rd_req_valid && w_hazard) || !i_rd_req_valid)) begin
            r_state <= WR;
            o_we_rf <= 1'b1;
            o_a3    <= w_head_addr;
            o_wd3   <= w_head_data;
          end else if (w_rd_fire) begin
            r_state   <= RD_ISSUE;
            o_a1      <= i_rd_addr_a;
            o_a2      <= i_rd_addr_b;
            r_legal_a <= addr_legal(i_rd_addr_a);
            r_legal_b <= addr_legal(i_rd_addr_b);
          end
        end
        WR: begin
          r_state <= IDLE;
          o_we_rf <= 1'b0;
        end
        RD_ISSUE: r_state <= RD_WAIT;
        RD_WAIT:  r_state <= RD_CAP;
        RD_CAP: begin
          r_state    <= IDLE;
          o_op_valid <= 1'b1;
          o_op_a     <= r_legal_a ? i_rd1 : '0;
          o_op_b     <= r_legal_b ? i_rd2 : '0;
        end
        default: begin
          r_state <= IDLE;
          o_we_rf <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb/tb_regfile_access_ctrl.sv - self-checking bench for regfile_access_ctrl with RF model and program-order reference
module tb_regfile_access_ctrl;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
  logic              op_valid;
  logic [DATA_W-1:0] op_a, op_b;
  logic              wb_valid, wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_addr_err, we_rf;
  logic [ADDR_W-1:0] a1, a2, a3;
  logic [DATA_W-1:0] wd3;
  logic [DATA_W-1:0] rd1 = '0;
  logic [DATA_W-1:0] rd2 = '0;

  always #5 clk = ~clk;

  regfile_access_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_req_valid(rd_req_valid), .o_rd_req_ready(rd_req_ready),
    .i_rd_addr_a(rd_addr_a), .i_rd_addr_b(rd_addr_b),
    .o_op_valid(op_valid), .o_op_a(op_a), .o_op_b(op_b),
    .i_wb_valid(wb_valid), .o_wb_ready(wb_ready),
    .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_wb_addr_err(wb_addr_err),
    .o_we_rf(we_rf), .o_a1(a1), .o_a2(a2), .o_a3(a3), .o_wd3(wd3),
    .i_rd1(rd1), .i_rd2(rd2)
  );

  // Register file: writes on negedge, read data registered on posedge when not writing.
  logic [DATA_W-1:0] rf [32];
  always @(negedge clk) if (we_rf === 1'b1) rf[a3] <= wd3;
  always @(posedge clk) if (we_rf !== 1'b1) begin rd1 <= rf[a1]; rd2 <= rf[a2]; end

  typedef struct {logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} wr_t;

  int                n_checks = 0;
  int                n_fail   = 0;
  int                cyc      = 0;
  logic [DATA_W-1:0] arch      [NUM_REGS];  // program-order value
  logic [DATA_W-1:0] committed [NUM_REGS];  // value written into the RF so far
  wr_t               mq[$];
  bit                rd_pend = 0;
  int                rd_due  = 0;
  logic [DATA_W-1:0] exp_a, exp_b;
  bit                exp_err = 0;
  bit                last_rd_fire = 0;
  logic [DATA_W-1:0] last_op_a, last_op_b;
  int                op_cyc = 0;
  int                hs_cyc = 0;
  bit                saw_err = 0;
  int                n_ops = 0;
  logic [ADDR_W-1:0] a3_hist[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check the cycle at negedge, advance the reference model.
  task automatic tick(input bit rv, input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                      input bit wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    bit busy, hz, rdy, wrdy;
    rd_req_valid = rv; rd_addr_a = ra; rd_addr_b = rb;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    @(negedge clk);
    check("op_valid", op_valid, rd_pend && (cyc == rd_due));
    if (op_valid === 1'b1) begin
      last_op_a = op_a; last_op_b = op_b; op_cyc = cyc; n_ops++;
    end
    if (rd_pend && cyc == rd_due) begin
      check("op_a", op_a, exp_a);
      check("op_b", op_b, exp_b);
      rd_pend = 0;
    end
    check("wb_addr_err", wb_addr_err, exp_err);
    if (wb_addr_err === 1'b1) saw_err = 1;
    wrdy = mq.size() < WB_DEPTH;
    check("wb_ready", wb_ready, wrdy);
    busy = rd_pend && (cyc < rd_due);
    if (busy) check("we_in_read", we_rf, 1'b0);
    hz = 0;
    foreach (mq[i]) if (mq[i].a == ra || mq[i].a == rb) hz = 1;
    rdy = !busy && (we_rf !== 1'b1) && wrdy && !hz;
    check("rd_req_ready", rd_req_ready, rdy);
    if (mq.size() == 0) begin
      check("we_no_pending", we_rf, 1'b0);
    end else if (we_rf === 1'b1) begin
      check("a3_order", a3, mq[0].a);
      check("wd3_order", wd3, mq[0].d);
      a3_hist.push_back(a3);
      committed[mq[0].a] = mq[0].d;
      void'(mq.pop_front());
    end
    last_rd_fire = rv && rdy;
    if (last_rd_fire) begin
      rd_pend = 1; rd_due = cyc + 4; hs_cyc = cyc;
      exp_a = (int'(ra) < NUM_REGS) ? arch[ra] : '0;
      exp_b = (int'(rb) < NUM_REGS) ? arch[rb] : '0;
    end
    exp_err = wv && wrdy && (int'(wa) >= NUM_REGS);
    if (wv && wrdy && int'(wa) < NUM_REGS) begin
      mq.push_back('{a: wa, d: wd});
      arch[wa] = wd;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset(input int n);
    rd_req_valid = 0; wb_valid = 0; rd_addr_a = 0; rd_addr_b = 0; wb_addr = 0; wb_data = 0;
    rst_n = 1'b0;
    #1;
    check("rst_we_rf", we_rf, 1'b0);
    check("rst_op_valid", op_valid, 1'b0);
    check("rst_a1", a1, 0);
    check("rst_a2", a2, 0);
    check("rst_a3", a3, 0);
    check("rst_wd3", wd3, 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_wb_addr_err", wb_addr_err, 1'b0);
    mq.delete();
    rd_pend = 0; exp_err = 0;
    for (int i = 0; i < NUM_REGS; i++) arch[i] = committed[i];
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
    rst_n = 1'b1;
    #1;
    check("rel_rd_req_ready", rd_req_ready, 1'b1);
    check("rel_wb_ready", wb_ready, 1'b1);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 32; i++) rf[i] = (i < NUM_REGS) ? DATA_W'(i * 32'h10101) : 26'h2AAAAAA;
    rf[1] = 26'h11;
    rf[2] = 26'h22;
    for (int i = 0; i < NUM_REGS; i++) begin arch[i] = rf[i]; committed[i] = rf[i]; end
    #2;
    apply_reset(2);

    // 1: plain read with 4-cycle latency and no write activity
    tick(1, 1, 2, 0, 0, 0);
    check("t1_handshake", rd_req_ready, 1'b0);
    idle(4);
    check("t1_op_a", last_op_a, 26'h11);
    check("t1_op_b", last_op_b, 26'h22);
    check("t1_latency", op_cyc - hs_cyc, 4);

    // 2: read of a register with a queued write waits for the write
    a3_hist.delete();
    tick(0, 0, 0, 1, 3, 26'h3FFFFFF);
    k = 0;
    do begin tick(1, 3, 0, 0, 0, 0); k++; end while (!last_rd_fire && k < 10);
    check("t2_fired", last_rd_fire, 1'b1);
    check("t2_wait", k > 1, 1'b1);
    check("t2_a3", a3_hist.size() == 1 && a3_hist[0] == 3, 1'b1);
    idle(5);
    check("t2_op_a", last_op_a, 26'h3FFFFFF);

    // 3: fill the queue behind a read in flight, then drain in order
    a3_hist.delete();
    tick(1, 1, 2, 1, 4, 26'h44);
    tick(0, 0, 0, 1, 5, 26'h55);
    tick(0, 0, 0, 1, 6, 26'h66);
    tick(0, 0, 0, 1, 7, 26'h77);
    check("t3_full", wb_ready, 1'b0);
    idle(12);
    check("t3_count", a3_hist.size(), 4);
    for (int i = 0; i < 4 && i < a3_hist.size(); i++) check("t3_a3_order", a3_hist[i], 4 + i);

    // 4: write accepted with the read is younger than the read
    tick(1, 8, 8, 1, 8, 26'h5);
    idle(8);
    check("t4_old_r8", last_op_a, 26'h080808);
    tick(1, 8, 0, 0, 0, 0);
    idle(5);
    check("t4_new_r8", last_op_a, 26'h5);

    // 5: illegal addresses
    saw_err = 0;
    tick(0, 0, 0, 1, 13, 26'h123);
    idle(2);
    check("t5_err_pulse", saw_err, 1'b1);
    tick(1, 13, 0, 0, 0, 0);
    idle(5);
    check("t5_op_a_zero", last_op_a, 0);

    // 6: reset during RD_WAIT with three queued writes
    tick(0, 0, 0, 1, 9, 26'h99);
    tick(1, 1, 2, 1, 10, 26'hAA);
    check("t6_read_first", rd_pend, 1'b1);
    tick(0, 0, 0, 1, 11, 26'hBB);
    n_ops = 0;
    apply_reset(2);
    idle(8);
    check("t6_no_op", n_ops, 0);

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 14)), ADDR_W'($urandom_range(0, 14)),
           $urandom_range(0, 2) != 0, ADDR_W'($urandom_range(0, 14)), DATA_W'($urandom));
    end
    k = 0;
    while ((mq.size() != 0 || rd_pend) && k < 40) begin idle(1); k++; end
    check("drain_done", mq.size(), 0);
    check("read_done", rd_pend, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
